// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared opcodes, funct codes and ID/EX record for the decode stage
package id_stage_pkg;

    localparam int ID_DW = 32;
    localparam int ID_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;

    typedef struct packed {
        logic [5:0]       funct;
        logic [ID_DW-1:0] operand_1;
        logic [ID_DW-1:0] operand_2;
        logic [4:0]       shamt;
        logic             wen;
        logic [ID_AW-1:0] waddr;
        logic             valid;
    } id_ex_t;

    function automatic logic is_alu_funct(input logic [5:0] f);
        return f inside {F_OR, F_ADDU, F_SUBU, F_SLLV, F_SRLV, F_SRAV};
    endfunction

endpackage

// File: rtl/id_forward_mux.sv
// rtl/id_forward_mux.sv - source operand select: r0, EX bypass, MEM bypass, then register file
module id_forward_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] raddr_i,
    input  logic [DATA_W-1:0] rf_rdata_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // EX is the younger producer, so it wins over MEM for the same register
    always_comb begin
        if (raddr_i == '0)
            rdata_o = '0;
        else if (ex_wen_i && (ex_waddr_i == raddr_i))
            rdata_o = ex_wdata_i;
        else if (mem_wen_i && (mem_waddr_i == raddr_i))
            rdata_o = mem_wdata_i;
        else
            rdata_o = rf_rdata_i;
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode with operand forwarding and ID/EX pipeline register
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic              inst_ready,
    input  logic              stall_in,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic [4:0]        shamt,
    output logic              write_reg_en,
    output logic [REG_AW-1:0] write_reg_addr,
    output logic              ex_valid,
    output logic              illegal_inst
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val, rt_val;
    id_ex_t            dec;
    logic              dec_illegal;
    id_ex_t            id_ex_d, id_ex_q;
    logic              illegal_d, illegal_q;

    assign opcode     = inst[31:26];
    assign rs         = inst[25:21];
    assign rt         = inst[20:16];
    assign rd         = inst[15:11];
    assign imm        = inst[15:0];
    assign rf_raddr1  = rs;
    assign rf_raddr2  = rt;
    assign inst_ready = !stall_in;

    id_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .raddr_i(rs), .rf_rdata_i(rf_rdata1),
        .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .mem_wen_i(mem_wen), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .rdata_o(rs_val)
    );

    id_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .raddr_i(rt), .rf_rdata_i(rf_rdata2),
        .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .mem_wen_i(mem_wen), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .rdata_o(rt_val)
    );

    // Unsupported encodings decode exactly like a NOP; only the sticky flag differs
    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (is_alu_funct(inst[5:0])) begin
                    dec.funct     = inst[5:0];
                    dec.operand_1 = rs_val;
                    dec.operand_2 = rt_val;
                    dec.shamt     = inst[10:6];
                    dec.waddr     = rd;
                    dec.wen       = (rd != '0);
                end else if (inst != '0) begin
                    dec_illegal = 1'b1;
                end
            end
            OP_ORI: begin
                dec.funct     = F_OR;
                dec.operand_1 = rs_val;
                dec.operand_2 = {{(DATA_W-16){1'b0}}, imm};
                dec.waddr     = rt;
                dec.wen       = (rt != '0);
            end
            OP_ADDIU: begin
                dec.funct     = F_ADDU;
                dec.operand_1 = rs_val;
                dec.operand_2 = {{(DATA_W-16){imm[15]}}, imm};
                dec.waddr     = rt;
                dec.wen       = (rt != '0);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        id_ex_d   = id_ex_q;
        illegal_d = illegal_q;
        if (flush) begin
            id_ex_d = '0;
        end else if (!stall_in) begin
            if (inst_valid) begin
                id_ex_d   = dec;
                illegal_d = illegal_q | dec_illegal;
            end else begin
                id_ex_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            id_ex_q   <= id_ex_d;
            illegal_q <= illegal_d;
        end
    end

    assign funct          = id_ex_q.funct;
    assign operand_1      = id_ex_q.operand_1;
    assign operand_2      = id_ex_q.operand_2;
    assign shamt          = id_ex_q.shamt;
    assign write_reg_en   = id_ex_q.wen;
    assign write_reg_addr = id_ex_q.waddr;
    assign ex_valid       = id_ex_q.valid;
    assign illegal_inst   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - vector table, corner sequences and randomized model comparison for id_stage
module tb_id_stage;

    typedef struct packed {
        logic [5:0]  funct;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  shamt;
        logic        wen;
        logic [4:0]  waddr;
        logic        valid;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] r1, r2;
        logic        xw;
        logic [4:0]  xa;
        logic [31:0] xd;
        logic        mw;
        logic [4:0]  ma;
        logic [31:0] md;
        out_t        exp;
    } vec_t;

    logic        clk, rst, inst_valid, inst_ready, stall_in, flush;
    logic [31:0] inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_wen, mem_wen;
    logic [4:0]  ex_waddr, mem_waddr;
    logic [31:0] ex_wdata, mem_wdata;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2;
    logic [4:0]  shamt;
    logic        write_reg_en;
    logic [4:0]  write_reg_addr;
    logic        ex_valid, illegal_inst;

    logic [31:0] rf [32];
    int          total = 0;
    int          bad   = 0;
    vec_t        vecs [12];
    out_t        exp_q, nxt, dec;
    logic        exp_ill, dill;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    id_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .stall_in(stall_in), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .funct(funct), .operand_1(operand_1), .operand_2(operand_2), .shamt(shamt),
        .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr),
        .ex_valid(ex_valid), .illegal_inst(illegal_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
        logic [31:0] w;
        w = 32'(s) * 32'h200000 + 32'(t) * 32'h10000 + 32'(d) * 32'h800 + 32'(sh) * 32'h40 + 32'(fn);
        return w;
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
        return 32'(op) * 32'h4000000 + 32'(s) * 32'h200000 + 32'(t) * 32'h10000 + 32'(im);
    endfunction

    function automatic out_t mk_o(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic w, input logic [4:0] wa, input logic v);
        out_t o;
        o.funct = f; o.op1 = a; o.op2 = b; o.shamt = sh; o.wen = w; o.waddr = wa; o.valid = v;
        return o;
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (ex_wen && ex_waddr == r) return ex_wdata;
        if (mem_wen && mem_waddr == r) return mem_wdata;
        return rf[r];
    endfunction

    function automatic void model_decode(input logic [31:0] w, output out_t o, output logic ill);
        int op, fn, s, t, d;
        op = int'(w / 32'h4000000);
        s  = int'((w / 32'h200000) % 32);
        t  = int'((w / 32'h10000) % 32);
        d  = int'((w / 32'h800) % 32);
        fn = int'(w % 64);
        o = mk_o(6'h0, 32'h0, 32'h0, 5'h0, 1'b0, 5'h0, 1'b1);
        ill = 1'b0;
        if (op == 0 && (fn == 'h25 || fn == 'h21 || fn == 'h23 || fn == 'h04 || fn == 'h06 || fn == 'h07))
            o = mk_o(6'(fn), src_val(5'(s)), src_val(5'(t)), 5'((w / 32'h40) % 32), d != 0, 5'(d), 1'b1);
        else if (op == 'h0D)
            o = mk_o(6'h25, src_val(5'(s)), w % 32'h10000, 5'h0, t != 0, 5'(t), 1'b1);
        else if (op == 'h09)
            o = mk_o(6'h21, src_val(5'(s)),
                     (w % 32'h10000 >= 32'h8000) ? (w % 32'h10000) + 32'hFFFF0000 : w % 32'h10000,
                     5'h0, t != 0, 5'(t), 1'b1);
        else if (w != 0)
            ill = 1'b1;
    endfunction

    task automatic check_out(input string nm, input out_t e, input logic e_ill);
        out_t a;
        a = mk_o(funct, operand_1, operand_2, shamt, write_reg_en, write_reg_addr, ex_valid);
        total++;
        if (a !== e || illegal_inst !== e_ill) begin
            bad++;
            $display("FAIL %s: got f=%h op1=%h op2=%h sh=%h wen=%b wa=%h v=%b ill=%b, want f=%h op1=%h op2=%h sh=%h wen=%b wa=%h v=%b ill=%b",
                     nm, a.funct, a.op1, a.op2, a.shamt, a.wen, a.waddr, a.valid, illegal_inst,
                     e.funct, e.op1, e.op2, e.shamt, e.wen, e.waddr, e.valid, e_ill);
        end
    endtask

    task automatic check_v(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        rf[1] = v.r1; rf[2] = v.r2;
        inst = v.inst; inst_valid = 1'b1;
        ex_wen = v.xw; ex_waddr = v.xa; ex_wdata = v.xd;
        mem_wen = v.mw; mem_waddr = v.ma; mem_wdata = v.md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_t zero, bubble_ill;
        zero = '0;
        rst = 1'b0; inst_valid = 1'b0; inst = '0; stall_in = 1'b0; flush = 1'b0;
        ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0; mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        vecs[0]  = '{mk_r(1,2,3,0,6'h21), 5, 7, 0, 0, 0, 0, 0, 0, mk_o(6'h21, 5, 7, 0, 1, 3, 1)};
        vecs[1]  = '{mk_i(6'h0D,0,4,16'h8001), 5, 7, 0, 0, 0, 0, 0, 0, mk_o(6'h25, 0, 32'h8001, 0, 1, 4, 1)};
        vecs[2]  = '{mk_i(6'h09,0,4,16'hFFFF), 5, 7, 0, 0, 0, 0, 0, 0, mk_o(6'h21, 0, 32'hFFFFFFFF, 0, 1, 4, 1)};
        vecs[3]  = '{mk_r(1,2,3,0,6'h23), 32'h11, 7, 1, 1, 32'hAA, 1, 1, 32'hBB, mk_o(6'h23, 32'hAA, 7, 0, 1, 3, 1)};
        vecs[4]  = '{mk_r(1,2,3,0,6'h23), 32'h11, 7, 0, 1, 32'hAA, 1, 1, 32'hBB, mk_o(6'h23, 32'hBB, 7, 0, 1, 3, 1)};
        vecs[5]  = '{mk_r(0,2,3,0,6'h25), 5, 7, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, mk_o(6'h25, 0, 7, 0, 1, 3, 1)};
        vecs[6]  = '{mk_r(1,2,5,3,6'h04), 5, 7, 0, 0, 0, 1, 2, 32'h40, mk_o(6'h04, 5, 32'h40, 3, 1, 5, 1)};
        vecs[7]  = '{mk_r(1,2,0,0,6'h07), 5, 7, 0, 0, 0, 0, 0, 0, mk_o(6'h07, 5, 7, 0, 0, 0, 1)};
        vecs[8]  = '{32'h0, 5, 7, 0, 0, 0, 0, 0, 0, mk_o(6'h00, 0, 0, 0, 0, 0, 1)};
        vecs[9]  = '{mk_i(6'h0D,2,1,16'h1234), 5, 7, 1, 1, 32'hAA, 0, 0, 0, mk_o(6'h25, 7, 32'h1234, 0, 1, 1, 1)};
        vecs[10] = '{mk_i(6'h09,2,6,16'h0003), 5, 7, 0, 0, 0, 1, 2, 32'h100, mk_o(6'h21, 32'h100, 3, 0, 1, 6, 1)};
        vecs[11] = '{mk_r(2,1,7,0,6'h06), 5, 7, 1, 2, 32'h55, 1, 1, 32'h66, mk_o(6'h06, 32'h55, 32'h66, 0, 1, 7, 1)};

        repeat (2) tick();
        check_out("reset_state", zero, 1'b0);
        @(negedge clk) rst = 1'b1;

        for (int k = 0; k < 12; k++) begin
            apply_vec(vecs[k]);
            #1;
            check_v($sformatf("vec%0d_raddr_ready", k), {17'h0, rf_raddr1, rf_raddr2, inst_ready},
                    {17'h0, vecs[k].inst[25:21], vecs[k].inst[20:16], 1'b1});
            tick();
            check_out($sformatf("vec%0d", k), vecs[k].exp, 1'b0);
            @(negedge clk);
        end

        apply_vec(vecs[0]);
        tick();
        check_out("stall_load", vecs[0].exp, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stall_in = 1'b1; inst = mk_i(6'h0D, 0, 9, 16'h7777); rf[1] = 32'h999;
            #1;
            check_v($sformatf("stall%0d_ready", c), {31'h0, inst_ready}, 32'h0);
            tick();
            check_out($sformatf("stall%0d_hold", c), vecs[0].exp, 1'b0);
        end
        @(negedge clk);
        stall_in = 1'b0; inst_valid = 1'b0;
        tick();
        check_out("stall_release_bubble", zero, 1'b0);

        @(negedge clk);
        apply_vec(vecs[1]);
        tick();
        @(negedge clk);
        flush = 1'b1; stall_in = 1'b1;
        tick();
        check_out("flush_beats_stall", zero, 1'b0);

        @(negedge clk);
        flush = 1'b0; stall_in = 1'b0; inst_valid = 1'b1; inst = 32'h8C000000;
        bubble_ill = mk_o(0, 0, 0, 0, 0, 0, 1);
        tick();
        check_out("illegal_load", bubble_ill, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        tick();
        check_out("illegal_after_flush", zero, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        apply_vec(vecs[0]);
        tick();
        check_out("illegal_sticky", vecs[0].exp, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_out("async_reset", zero, 1'b0);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        exp_q = '0; exp_ill = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int kind;
            logic [5:0] fl [6];
            fl = '{6'h25, 6'h21, 6'h23, 6'h04, 6'h06, 6'h07};
            kind = $urandom_range(0, 9);
            if (kind <= 4)
                inst = mk_r($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,31), fl[$urandom_range(0,5)]);
            else if (kind == 5)
                inst = mk_i(6'h0D, $urandom_range(0,3), $urandom_range(0,3), 16'($urandom));
            else if (kind == 6)
                inst = mk_i(6'h09, $urandom_range(0,3), $urandom_range(0,3), 16'($urandom));
            else if (kind == 7 && $urandom_range(0,7) == 0)
                inst = ($urandom_range(0,1) == 1) ? 32'hAC000000 : mk_r(1, 2, 3, 0, 6'h20);
            else
                inst = 32'h0;
            inst_valid = ($urandom_range(0,3) != 0);
            stall_in   = ($urandom_range(0,4) == 0);
            flush      = ($urandom_range(0,7) == 0);
            ex_wen  = $urandom_range(0,1); ex_waddr  = 5'($urandom_range(0,3)); ex_wdata  = $urandom;
            mem_wen = $urandom_range(0,1); mem_waddr = 5'($urandom_range(0,3)); mem_wdata = $urandom;
            #1;
            model_decode(inst, dec, dill);
            nxt = exp_q;
            if (flush) nxt = '0;
            else if (!stall_in) begin
                if (inst_valid) begin
                    nxt = dec;
                    exp_ill = exp_ill | dill;
                end else nxt = '0;
            end
            exp_q = nxt;
            check_v($sformatf("rand%0d_ready", n), {31'h0, inst_ready}, {31'h0, !stall_in});
            tick();
            check_out($sformatf("rand%0d", n), exp_q, exp_ill);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
